// File: rtl/codec_intf_param_if.sv
// Host and codec-pin bundle for codec_intf_param; slave is the codec engine, master its
// environment.
interface codec_intf_param_if #(
   parameter int unsigned DW = 16
) ();
   logic          fmt;
   logic          mute;
   logic          tx_wr;
   logic [DW-1:0] lft_out;
   logic [DW-1:0] rht_out;
   logic          clr_err;
   logic          SDout;
   logic          tx_ready;
   logic          tx_underrun;
   logic          rx_valid;
   logic [DW-1:0] lft_in;
   logic [DW-1:0] rht_in;
   logic          MCLK;
   logic          SCLK;
   logic          LRCLK;
   logic          codec_rstn;
   logic          SDin;

   modport master (
      output fmt, mute, tx_wr, lft_out, rht_out, clr_err, SDout,
      input  tx_ready, tx_underrun, rx_valid, lft_in, rht_in,
      input  MCLK, SCLK, LRCLK, codec_rstn, SDin
   );

   modport slave (
      input  fmt, mute, tx_wr, lft_out, rht_out, clr_err, SDout,
      output tx_ready, tx_underrun, rx_valid, lft_in, rht_in,
      output MCLK, SCLK, LRCLK, codec_rstn, SDin
   );
endinterface

// File: rtl/codec_intf_param.sv
// Serial audio codec interface: frame counter derived clocks, left-justified or I2S framing,
// double-buffered stereo TX and frame-coherent stereo RX.
module codec_intf_param #(
   parameter int unsigned DW         = 16,
   parameter int unsigned SLOT_BITS  = 32,
   parameter int unsigned SCLK_HALF  = 8,
   parameter int unsigned RST_FRAMES = 1
) (
   input logic               clk,
   input logic               rst_n,
   codec_intf_param_if.slave bus
);
   localparam int unsigned F   = 4 * SLOT_BITS * SCLK_HALF;
   localparam int unsigned CW  = $clog2(F);
   localparam int unsigned SHW = $clog2(SCLK_HALF);
   localparam int unsigned KW  = $clog2(SLOT_BITS);
   localparam int unsigned RW  = $clog2(RST_FRAMES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] slot_cur, slot_nxt;
   logic          frame_end, sclk_rise, sclk_fall_nxt, underrun_set;
   logic          fmt_q, fmt_d;
   logic [DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DW-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic [DW-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
   logic [DW-1:0] lft_in_q, lft_in_d, rht_in_q, rht_in_d;
   logic          tx_ready_q, tx_ready_d;
   logic          tx_underrun_q, tx_underrun_d;
   logic          rx_valid_q, rx_valid_d;
   logic          sdin_q, sdin_d;
   logic          codec_rstn_q, codec_rstn_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;

   function automatic logic in_payload(input int unsigned k, input int unsigned d);
      return (k >= d) && (k < d + DW);
   endfunction

   function automatic logic payload_bit(input logic [DW-1:0] smp, input int unsigned k,
                                        input int unsigned d);
      logic [DW-1:0] sh;
      sh = smp << (k - d);
      return in_payload(k, d) && sh[DW-1];
   endfunction

   // F is a power of two, so the counter wraps on its own.
   assign cnt_d         = cnt_q + CW'(1);
   assign slot_cur      = cnt_q[CW-2:SHW+1];
   assign slot_nxt      = cnt_d[CW-2:SHW+1];
   assign frame_end     = &cnt_q;
   assign sclk_rise     = (cnt_q[SHW:0] == (SHW+1)'(SCLK_HALF - 1));
   assign sclk_fall_nxt = (cnt_d[SHW:0] == '0);

   always_comb begin
      fmt_d        = fmt_q;
      hold_l_d     = hold_l_q;
      hold_r_d     = hold_r_q;
      tx_l_d       = tx_l_q;
      tx_r_d       = tx_r_q;
      tx_ready_d   = tx_ready_q;
      underrun_set = 1'b0;
      rx_l_d       = rx_l_q;
      rx_r_d       = rx_r_q;
      lft_in_d     = lft_in_q;
      rht_in_d     = rht_in_q;
      rx_valid_d   = 1'b0;
      codec_rstn_d = codec_rstn_q;
      rst_cnt_d    = rst_cnt_q;
      sdin_d       = sdin_q;

      if (bus.tx_wr) begin
         hold_l_d   = bus.lft_out;
         hold_r_d   = bus.rht_out;
         tx_ready_d = 1'b0;
      end

      // Frame boundary: old holding content moves out, a same-cycle write stays held.
      if (frame_end) begin
         fmt_d = bus.fmt;
         if (tx_ready_q) begin
            underrun_set = 1'b1;
            if (bus.mute) begin
               tx_l_d = '0;
               tx_r_d = '0;
            end
         end else begin
            tx_l_d = bus.mute ? '0 : hold_l_q;
            tx_r_d = bus.mute ? '0 : hold_r_q;
            if (!bus.tx_wr) begin
               tx_ready_d = 1'b1;
            end
         end

         if (codec_rstn_q) begin
            rx_valid_d = 1'b1;
            lft_in_d   = rx_l_q;
            rht_in_d   = rx_r_q;
         end else if (rst_cnt_q == RW'(RST_FRAMES - 1)) begin
            codec_rstn_d = 1'b1;
         end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
         end
      end

      tx_underrun_d = underrun_set | (tx_underrun_q & ~bus.clr_err);

      if (sclk_fall_nxt) begin
         sdin_d = payload_bit(cnt_d[CW-1] ? tx_r_d : tx_l_d, 32'(slot_nxt), 32'(fmt_d));
      end

      if (sclk_rise && in_payload(32'(slot_cur), 32'(fmt_q))) begin
         if (cnt_q[CW-1]) begin
            rx_r_d = {rx_r_q[DW-2:0], bus.SDout};
         end else begin
            rx_l_d = {rx_l_q[DW-2:0], bus.SDout};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         fmt_q         <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         tx_l_q        <= '0;
         tx_r_q        <= '0;
         rx_l_q        <= '0;
         rx_r_q        <= '0;
         lft_in_q      <= '0;
         rht_in_q      <= '0;
         tx_ready_q    <= 1'b1;
         tx_underrun_q <= 1'b0;
         rx_valid_q    <= 1'b0;
         sdin_q        <= 1'b0;
         codec_rstn_q  <= 1'b0;
         rst_cnt_q     <= '0;
      end else begin
         cnt_q         <= cnt_d;
         fmt_q         <= fmt_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         tx_l_q        <= tx_l_d;
         tx_r_q        <= tx_r_d;
         rx_l_q        <= rx_l_d;
         rx_r_q        <= rx_r_d;
         lft_in_q      <= lft_in_d;
         rht_in_q      <= rht_in_d;
         tx_ready_q    <= tx_ready_d;
         tx_underrun_q <= tx_underrun_d;
         rx_valid_q    <= rx_valid_d;
         sdin_q        <= sdin_d;
         codec_rstn_q  <= codec_rstn_d;
         rst_cnt_q     <= rst_cnt_d;
      end
   end

   assign bus.MCLK        = cnt_q[1];
   assign bus.SCLK        = cnt_q[SHW];
   assign bus.LRCLK       = cnt_q[CW-1];
   assign bus.SDin        = sdin_q;
   assign bus.codec_rstn  = codec_rstn_q;
   assign bus.tx_ready    = tx_ready_q;
   assign bus.tx_underrun = tx_underrun_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.lft_in      = lft_in_q;
   assign bus.rht_in      = rht_in_q;
endmodule

// File: tb/tb_codec_intf_param.sv
// Directed bench: default instance with codec model or loopback, plus a 24-bit loopback
// instance running alongside.
module tb_codec_intf_param;
   logic clk;
   logic rst_n;
   logic lb;
   logic [9:0]  tb_cnt;
   logic [15:0] codec_word, codec_shift;
   logic        codec_sd;
   int n_tests;
   int n_fail;

   codec_intf_param_if #(.DW(16)) bus ();
   codec_intf_param_if #(.DW(24)) bus24 ();

   codec_intf_param u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   codec_intf_param #(
      .DW         (24),
      .SLOT_BITS  (32),
      .SCLK_HALF  (4),
      .RST_FRAMES (1)
   ) u_dut24 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench time base: cycles since reset release, modulo the 1024-cycle default frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cnt <= '0;
      else        tb_cnt <= tb_cnt + 10'd1;
   end

   // Left-justified codec returning L=8001, R=7FFE.
   always_comb begin
      codec_word  = tb_cnt[9] ? 16'h7FFE : 16'h8001;
      codec_shift = codec_word << tb_cnt[8:4];
      codec_sd    = (tb_cnt[8:4] < 5'd16) ? codec_shift[15] : 1'b0;
   end

   assign bus.SDout   = lb ? bus.SDin : codec_sd;
   assign bus24.SDout = bus24.SDin;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cnt(input int unsigned v);
      for (int i = 0; i < 2048; i++) begin
         @(posedge clk);
         #1;
         if (32'(tb_cnt) == v) break;
      end
   endtask

   task automatic count_to_rx(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!bus.rx_valid && cycles < 3000);
   endtask

   task automatic tx_write(input logic [15:0] l, input logic [15:0] r);
      bus.tx_wr   = 1'b1;
      bus.lft_out = l;
      bus.rht_out = r;
   endtask

   initial begin
      int n;
      logic got_rx;
      logic trail_bad;
      logic sd_or;
      n_tests = 0;
      n_fail  = 0;
      lb      = 1'b0;
      rst_n   = 1'b0;
      bus.fmt = 1'b0; bus.mute = 1'b0; bus.tx_wr = 1'b0; bus.clr_err = 1'b0;
      bus.lft_out = '0; bus.rht_out = '0;
      bus24.fmt = 1'b0; bus24.mute = 1'b0; bus24.tx_wr = 1'b0; bus24.clr_err = 1'b0;
      bus24.lft_out = '0; bus24.rht_out = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_ready",   32'(bus.tx_ready), 1);
      check("rst_underrun",   32'(bus.tx_underrun), 0);
      check("rst_rx_valid",   32'(bus.rx_valid), 0);
      check("rst_lft_in",     32'(bus.lft_in), 0);
      check("rst_rht_in",     32'(bus.rht_in), 0);
      check("rst_clocks",     32'({bus.MCLK, bus.SCLK, bus.LRCLK}), 0);
      check("rst_codec_rstn", 32'(bus.codec_rstn), 0);
      check("rst_sdin",       32'(bus.SDin), 0);

      // Release; the 24-bit instance gets its sample straight away.
      rst_n = 1'b1;
      bus24.tx_wr = 1'b1; bus24.lft_out = 24'h800001; bus24.rht_out = 24'h7FFFFE;
      n = 0; got_rx = 1'b0; trail_bad = 1'b0;
      while (n < 3000 && !got_rx) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) bus24.tx_wr = 1'b0;
         if (n == 513) check("dw24_sdin_msb",  32'(bus24.SDin), 1);
         if (n == 521) check("dw24_sdin_s1",   32'(bus24.SDin), 0);
         if (n == 697) check("dw24_sdin_lsb",  32'(bus24.SDin), 1);
         if (n >= 512 && n < 768 && (n % 256) / 8 >= 24 && bus24.SDin) trail_bad = 1'b1;
         if (n == 1023) check("codec_rstn_low", 32'(bus.codec_rstn), 0);
         if (n == 1024) begin
            check("codec_rstn_high", 32'(bus.codec_rstn), 1);
            check("dw24_rx_valid",   32'(bus24.rx_valid), 1);
            check("dw24_lft_in",     32'(bus24.lft_in), 'h800001);
            check("dw24_rht_in",     32'(bus24.rht_in), 'h7FFFFE);
         end
         got_rx = bus.rx_valid;
      end
      check("dw24_trailing_zero", 32'(trail_bad), 0);
      check("first_rx_cycle", n, 2048);
      check("codec_lft_in", 32'(bus.lft_in), 'h8001);
      check("codec_rht_in", 32'(bus.rht_in), 'h7FFE);
      @(posedge clk);
      #1;
      check("rx_pulse_width", 32'(bus.rx_valid), 0);
      count_to_rx(n);
      check("rx_period", n, 1023);
      check("codec_lft_in2", 32'(bus.lft_in), 'h8001);
      check("underrun_idle", 32'(bus.tx_underrun), 1);

      bus.clr_err = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_err = 1'b0;
      check("clr_err_clears", 32'(bus.tx_underrun), 0);

      // I2S loopback.
      lb = 1'b1;
      bus.fmt = 1'b1;
      tx_write(16'hA5C3, 16'h3C5A);
      @(posedge clk);
      #1;
      bus.tx_wr = 1'b0;
      check("wr_tx_ready_low", 32'(bus.tx_ready), 0);
      wait_cnt(0);
      check("start_tx_ready",  32'(bus.tx_ready), 1);
      check("start_no_under",  32'(bus.tx_underrun), 0);
      wait_cnt(8);
      check("i2s_slot0", 32'(bus.SDin), 0);
      wait_cnt(24);
      check("i2s_msb",   32'(bus.SDin), 1);
      wait_cnt(40);
      check("i2s_l_b14", 32'(bus.SDin), 0);
      wait_cnt(568);
      check("i2s_r_b13", 32'(bus.SDin), 1);
      wait_cnt(0);
      check("lb_rx_valid", 32'(bus.rx_valid), 1);
      check("lb_lft_in",   32'(bus.lft_in), 'hA5C3);
      check("lb_rht_in",   32'(bus.rht_in), 'h3C5A);
      check("lb_underrun", 32'(bus.tx_underrun), 1);
      wait_cnt(0);
      check("repeat_lft_in", 32'(bus.lft_in), 'hA5C3);
      check("repeat_rht_in", 32'(bus.rht_in), 'h3C5A);

      // Clear in the same cycle as a new underrun.
      wait_cnt(1023);
      bus.clr_err = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_err = 1'b0;
      check("set_wins", 32'(bus.tx_underrun), 1);
      bus.clr_err = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_err = 1'b0;
      check("clr_err_again", 32'(bus.tx_underrun), 0);

      // Overwrite while full, then a write in the frame-boundary cycle.
      tx_write(16'h5555, 16'h6666);
      @(posedge clk);
      #1;
      tx_write(16'h1111, 16'h2222);
      @(posedge clk);
      #1;
      bus.tx_wr = 1'b0;
      wait_cnt(1023);
      tx_write(16'h3333, 16'h4444);
      @(posedge clk);
      #1;
      bus.tx_wr = 1'b0;
      check("edge_wr_ready",    32'(bus.tx_ready), 0);
      check("edge_wr_no_under", 32'(bus.tx_underrun), 0);
      wait_cnt(0);
      check("newest_lft_in",  32'(bus.lft_in), 'h1111);
      check("newest_rht_in",  32'(bus.rht_in), 'h2222);
      check("held_tx_ready",  32'(bus.tx_ready), 1);
      wait_cnt(0);
      check("held_lft_in", 32'(bus.lft_in), 'h3333);
      check("held_rht_in", 32'(bus.rht_in), 'h4444);

      // Reset mid-frame at cnt 700 with data pending.
      tx_write(16'h7FFF, 16'h0001);
      @(posedge clk);
      #1;
      bus.tx_wr = 1'b0;
      wait_cnt(700);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_ready",  32'(bus.tx_ready), 1);
      check("mid_rst_underrun",  32'(bus.tx_underrun), 0);
      check("mid_rst_lft_in",    32'(bus.lft_in), 0);
      check("mid_rst_rht_in",    32'(bus.rht_in), 0);
      check("mid_rst_clocks",    32'({bus.MCLK, bus.SCLK, bus.LRCLK}), 0);
      check("mid_rst_codec_rst", 32'(bus.codec_rstn), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_to_rx(n);
      check("post_rst_first_rx", n, 2048);
      check("post_rst_lft_in", 32'(bus.lft_in), 0);

      // Muted frame: full-scale data must not reach SDin.
      bus.mute = 1'b1;
      tx_write(16'h7FFF, 16'h7FFF);
      @(posedge clk);
      #1;
      bus.tx_wr = 1'b0;
      wait_cnt(0);
      bus.mute = 1'b0;
      check("mute_tx_ready", 32'(bus.tx_ready), 1);
      sd_or = bus.SDin;
      repeat (1023) begin
         @(posedge clk);
         #1;
         sd_or = sd_or | bus.SDin;
      end
      check("mute_sdin_zero", 32'(sd_or), 0);
      @(posedge clk);
      #1;
      check("mute_rx_valid", 32'(bus.rx_valid), 1);
      check("mute_rx_lft",   32'(bus.lft_in), 0);
      check("mute_rx_rht",   32'(bus.rht_in), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
